// File: rtl/servo_pkg.sv
// Shared constants for the multi-channel servo controller.
// Tick timing, frame defaults, register offsets and prescaler sizing.
package servo_pkg;

  // One position step is 6.35 us, held here in units of 10 ns.
  localparam int STEP_10NS        = 635;
  localparam int MIN_TICKS_DEF    = 91;
  localparam int PERIOD_TICKS_DEF = 3150;
  localparam int FRAME_W          = 12;
  localparam int POS_MAX          = 255;

  localparam int TARGET_OFS = 0;

  function automatic int enable_ofs(int channels);
    return channels;
  endfunction

  function automatic int slew_ofs(int channels);
    return channels + 1;
  endfunction

  function automatic int status_ofs(int channels);
    return channels + 2;
  endfunction

  // Clocks per tick: ceil(6.35e-6 * f_cpu).
  function automatic int tick_div(longint f_cpu);
    longint num;
    num = f_cpu * longint'(STEP_10NS) + 64'd99_999_999;
    return int'(num / 64'd100_000_000);
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: TARGET/CUR registers, per-frame slew step, pulse compare.
// Ports: frame timing in, shared slew/enable, target write, pin/target/at_target out.
module servo_channel
  import servo_pkg::*;
#(
  parameter int MIN_TICKS = MIN_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [FRAME_W-1:0] frame_count,
  input  logic [7:0]         slew,
  input  logic               enable,
  input  logic               enable_lat,
  input  logic               target_we,
  input  logic [7:0]         target_wdata,
  output logic               pin,
  output logic [7:0]         target,
  output logic               at_target
);

  logic [7:0]        cur;
  logic [7:0]        cur_next;
  logic [7:0]        mag;
  logic [7:0]        step;
  logic signed [8:0] diff;
  logic [FRAME_W-1:0] width;

  // 9-bit signed difference: the step is clamped to |diff|,
  // so CUR lands exactly on TARGET and never wraps.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    mag  = diff[8] ? 8'(-diff) : diff[7:0];
    step = (slew < mag) ? slew : mag;
    if (!enable || slew == 8'd0) begin
      cur_next = target;
    end else if (diff[8]) begin
      cur_next = cur - step;
    end else begin
      cur_next = cur + step;
    end
  end

  assign width     = FRAME_W'(MIN_TICKS) + {4'b0, cur};
  assign at_target = (cur == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
    end else if (target_we) begin
      target <= target_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (frame_start) begin
      cur <= cur_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin <= 1'b0;
    end else begin
      pin <= enable_lat && (frame_count < width);
    end
  end

endmodule

// File: rtl/servo_multi.sv
// Multi-channel hobby-servo PWM controller on the 8-bit peripheral bus.
// Ports: clk/rst, din/address/w_en/r_en/dout bus, servo_pins[CHANNELS].
module servo_multi
  import servo_pkg::*;
#(
  parameter int         F_CPU        = 16000000,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         CHANNELS     = 4,
  parameter int         PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int         MIN_TICKS    = MIN_TICKS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic [7:0]          address,
  input  logic                w_en,
  input  logic                r_en,
  output logic [7:0]          dout,
  output logic [CHANNELS-1:0] servo_pins
);

  localparam int TICK_DIV   = tick_div(longint'(F_CPU));
  localparam int ENABLE_OFS = enable_ofs(CHANNELS);
  localparam int SLEW_OFS   = slew_ofs(CHANNELS);
  localparam int STATUS_OFS = status_ofs(CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("servo_multi: CHANNELS=%0d outside 1..8", CHANNELS);
  end

  // The longest pulse must end inside the frame and fit 12 bits.
  if (PERIOD_TICKS <= MIN_TICKS + POS_MAX ||
      PERIOD_TICKS > (1 << FRAME_W)) begin : g_bad_period
    $error("servo_multi: PERIOD_TICKS=%0d out of range", PERIOD_TICKS);
  end

  if (TICK_DIV < 1 || TICK_DIV > 65536) begin : g_bad_tick
    $error("servo_multi: TICK_DIV=%0d out of range", TICK_DIV);
  end

  logic [15:0]         presc;
  logic                tick;
  logic [FRAME_W-1:0]  frame_count;
  logic                frame_start;
  logic [7:0]          offset;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] enable_lat;
  logic [CHANNELS-1:0] tgt_we;
  logic [CHANNELS-1:0] at_target;
  logic [7:0]          slew;
  logic [7:0]          targets [CHANNELS];
  logic                en_we;
  logic                slew_we;
  logic [7:0]          en8;
  logic [7:0]          st8;
  logic [7:0]          rdata;

  assign tick        = (presc == 16'(TICK_DIV - 1));
  assign frame_start = tick &&
                       (frame_count == FRAME_W'(PERIOD_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= '0;
    end else if (tick) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  // Addresses below the base wrap to large offsets and decode as unmapped.
  assign offset  = address - BASE_ADDRESS;
  assign en_we   = w_en && (offset == 8'(ENABLE_OFS));
  assign slew_we = w_en && (offset == 8'(SLEW_OFS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= '0;
    end else if (en_we) begin
      enable <= din[CHANNELS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slew <= '0;
    end else if (slew_we) begin
      slew <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_lat <= '0;
    end else if (frame_start) begin
      enable_lat <= enable;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign tgt_we[i] = w_en && (offset == 8'(TARGET_OFS + i));

    servo_channel #(
      .MIN_TICKS (MIN_TICKS)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .frame_count  (frame_count),
      .slew         (slew),
      .enable       (enable[i]),
      .enable_lat   (enable_lat[i]),
      .target_we    (tgt_we[i]),
      .target_wdata (din),
      .pin          (servo_pins[i]),
      .target       (targets[i]),
      .at_target    (at_target[i])
    );
  end

  always_comb begin
    en8 = '0;
    st8 = '0;
    en8[CHANNELS-1:0] = enable;
    st8[CHANNELS-1:0] = at_target;
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (offset == 8'(TARGET_OFS + i)) begin
        rdata = targets[i];
      end
    end
    if (offset == 8'(ENABLE_OFS)) begin
      rdata = en8;
    end
    if (offset == 8'(SLEW_OFS)) begin
      rdata = slew;
    end
    if (offset == 8'(STATUS_OFS)) begin
      rdata = st8;
    end
  end

  // Registered read: a same-edge write is not yet visible, so the
  // old value is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= r_en ? rdata : 8'd0;
    end
  end

endmodule

// File: tb/tb_servo_multi.sv
// Self-checking bench for servo_multi with a frame-level reference model.
// Pulse widths per frame, register reads, and async reset are checked.
module tb_servo_multi;

  localparam int         CH     = 4;
  localparam int         F_CPU  = 300000;
  localparam int         TD     = 2;   // ceil(6.35e-6 * 300000)
  localparam int         PERIOD = 400;
  localparam int         MINT   = 91;
  localparam int         FRAME  = PERIOD * TD;
  localparam logic [7:0] BASE   = 8'h10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    din = '0;
  logic [7:0]    address = '0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [7:0]    dout;
  logic [CH-1:0] servo_pins;

  servo_multi #(
    .F_CPU        (F_CPU),
    .BASE_ADDRESS (BASE),
    .CHANNELS     (CH),
    .PERIOD_TICKS (PERIOD),
    .MIN_TICKS    (MINT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .address    (address),
    .w_en       (w_en),
    .r_en       (r_en),
    .dout       (dout),
    .servo_pins (servo_pins)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_tgt [CH];
  int m_cur [CH];
  int m_en;
  int m_en_lat;
  int m_slew;
  int edges;
  int hi    [CH];
  int exp_w [CH];
  int rd_exp;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_read(logic [7:0] a);
    int off;
    int s;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < CH) return m_tgt[off];
    if (off == CH) return m_en;
    if (off == CH + 1) return m_slew;
    if (off == CH + 2) begin
      s = 0;
      for (int i = 0; i < CH; i++)
        if (m_cur[i] == m_tgt[i]) s = s | (1 << i);
      return s;
    end
    return 0;
  endfunction

  function automatic void m_write(logic [7:0] a, logic [7:0] d);
    int off;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < CH) m_tgt[off] = int'(d);
    else if (off == CH) m_en = int'(d) & ((1 << CH) - 1);
    else if (off == CH + 1) m_slew = int'(d);
  endfunction

  function automatic void m_frame();
    int d;
    m_en_lat = m_en;
    for (int i = 0; i < CH; i++) begin
      if (((m_en >> i) & 1) == 0 || m_slew == 0) begin
        m_cur[i] = m_tgt[i];
      end else begin
        d = m_tgt[i] - m_cur[i];
        if (d > 0) m_cur[i] += (d < m_slew) ? d : m_slew;
        else m_cur[i] -= (-d < m_slew) ? -d : m_slew;
      end
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
      hi[i]    = 0;
      exp_w[i] = 0;
    end
    m_en = 0;
    m_en_lat = 0;
    m_slew = 0;
    edges = 0;
    rd_exp = 0;
  endfunction

  // One clock: model follows the edge, pins sampled at the negedge,
  // and each frame's pulse widths are compared at the frame boundary.
  task automatic step();
    @(posedge clk);
    edges++;
    rd_exp = r_en ? m_read(address) : 0;
    if (edges % FRAME == 0) m_frame();
    if (w_en) m_write(address, din);
    @(negedge clk);
    for (int i = 0; i < CH; i++)
      if (servo_pins[i]) hi[i]++;
    if (edges % FRAME == 0) begin
      for (int i = 0; i < CH; i++) begin
        check($sformatf("width%0d", i), hi[i], exp_w[i]);
        hi[i] = 0;
        exp_w[i] = ((m_en_lat >> i) & 1) != 0 ?
                   (MINT + m_cur[i]) * TD : 0;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic next_frame();
    step();
    while (edges % FRAME != 0) step();
  endtask

  task automatic wr_a(logic [7:0] a, logic [7:0] d);
    address = a;
    din = d;
    w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  task automatic wr(int off, int d);
    wr_a(BASE + 8'(off), 8'(d));
  endtask

  task automatic rd(string tag, logic [7:0] a);
    address = a;
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check(tag, dout, rd_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_pins", servo_pins, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    idle(5);
    check("idle_dout", dout, 0);
    next_frame();
    next_frame();

    wr(0, 0);
    wr(CH, 8'h01);
    next_frame();
    next_frame();
    wr(0, 255);
    next_frame();
    next_frame();

    wr(1, 50);
    wr(CH, 8'h03);
    next_frame();
    next_frame();
    idle(50);
    check("mid_pulse1", servo_pins[1], 1);
    wr(1, 200);
    rd("status_pre", BASE + 8'(CH + 2));
    next_frame();
    rd("status_post", BASE + 8'(CH + 2));
    next_frame();

    wr(CH + 1, 10);
    wr(2, 35);
    wr(CH, 8'h07);
    repeat (5) begin
      next_frame();
      rd("status_slew", BASE + 8'(CH + 2));
    end
    next_frame();

    wr(0, 5);
    address = BASE;
    din = 8'd9;
    w_en = 1'b1;
    r_en = 1'b1;
    step();
    w_en = 1'b0;
    r_en = 1'b0;
    check("rw_old", dout, rd_exp);
    rd("rw_new", BASE);
    rd("unmapped", BASE + 8'(CH + 3));
    rd("below_base", 8'h05);
    wr(CH, 8'hFF);
    rd("enable_hi", BASE + 8'(CH));
    rd("slew_rd", BASE + 8'(CH + 1));

    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 5)
        wr_a(BASE + 8'($urandom_range(0, CH + 3)), 8'($urandom));
      else if (op < 8)
        rd("rnd_rd", BASE + 8'($urandom_range(0, CH + 3)));
      else if (op == 8)
        wr_a(8'($urandom), 8'($urandom));
      else
        rd("rnd_any", 8'($urandom));
      idle(int'($urandom_range(0, 300)));
    end
    next_frame();
    next_frame();

    wr(0, 255);
    wr(CH, 8'h01);
    wr(CH + 1, 0);
    next_frame();
    next_frame();
    idle(50);
    check("pre_rst_pin0", servo_pins[0],
          ((edges % FRAME) >= 1 && (edges % FRAME) <= exp_w[0]) ? 1 : 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pins", servo_pins, 0);
    check("async_rst_dout", dout, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int a = 0; a <= CH + 2; a++)
      rd($sformatf("post_rst_reg%0d", a), BASE + 8'(a));
    wr(0, 0);
    wr(CH, 8'h01);
    next_frame();
    next_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_multi.md
Name: servo_multi

Overview:
- Parametrised multi-channel successor to the single-channel servo PWM controller; CHANNELS independent hobby-servo outputs sharing one prescaler and one 20 ms frame counter.
- Memory-mapped on the 8-bit peripheral bus (din/address/w_en/r_en/dout).
- Adds per-channel enable, a programmable slew limit for ramped motion, at-target status, and glitch-free updates: new positions and enables apply only at frame boundaries.

Parameters:
- F_CPU, 16000000, system clock frequency in Hz.
- BASE_ADDRESS, 8'h00, first bus address of the register block.
- CHANNELS, 4, number of servo outputs, legal range 1..8.
- PERIOD_TICKS, 3150, ticks per frame (about 20 ms).
- MIN_TICKS, 91, pulse width in ticks at position 0 (about 580 us).
- TICK_DIV (localparam), ceil(6.35e-6*F_CPU), clocks per tick; 102 at 16 MHz.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  8  write data.
- address  in  8  register address.
- w_en  in  1  write strobe, single cycle.
- r_en  in  1  read strobe.
- dout  out  8  registered read data.
- servo_pins  out  CHANNELS  PWM outputs, bit i = channel i.

Behaviour:
- Register map, offsets from BASE_ADDRESS:
  - 0..CHANNELS-1: TARGET[i], R/W.
  - CHANNELS: ENABLE, R/W; bits [CHANNELS-1:0] used, upper bits write-ignored and read 0.
  - CHANNELS+1: SLEW, R/W; 0 = immediate, else the maximum position steps per frame.
  - CHANNELS+2: STATUS, RO; bit i = 1 when CUR[i] == TARGET[i].
- Writes: a write to STATUS or to an unmapped address is ignored. Writes land on the clk edge where w_en=1.
- Reads: dout updates every clk.
  - If r_en=1 and the address is mapped, dout = register value on the next edge (1-cycle latency).
  - Otherwise dout = 0.
  - w_en and r_en together at the same address: the write occurs and dout returns the pre-write value.
- Reset (async, while rst=1): TARGET, CUR, ENABLE, ENABLE_LAT, SLEW, prescaler, frame counter, dout and servo_pins all go to 0. Reset mid-pulse forces the pins low immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-clock pulse on the wrap cycle, giving a period of exactly TICK_DIV clocks.
- Frame counter:
  - 12-bit; advances on tick over 0..PERIOD_TICKS-1, then wraps to 0.
  - frame_start = the tick on which the counter wraps to 0.
- At frame_start, ENABLE_LAT <= ENABLE, and per channel:
  - If ENABLE bit clear, or SLEW == 0: CUR[i] <= TARGET[i].
  - Otherwise CUR[i] moves toward TARGET[i] by min(SLEW, |TARGET-CUR|). The difference is computed in 9-bit signed form, so there is never overshoot or wrap.
- CUR changes only at frame_start, so a write during a frame never alters the pulse in progress.
- Pin output (registered, 1-clk latency): servo_pins[i] <= ENABLE_LAT[i] && (frame_count < MIN_TICKS + CUR[i]). The sum is 12-bit, maximum 346.
- Disabled channel: pin held low; CUR tracks TARGET, so re-enabling starts at TARGET with no ramp.
- Out-of-range PERIOD_TICKS or CHANNELS is a configuration error and must be flagged with a generate-time $error.

Decomposition:
- Shared package servo_pkg holds:
  - tick constants: 6.35 us step, MIN_TICKS, PERIOD_TICKS;
  - register offset constants: TARGET_OFS=0, ENABLE_OFS, SLEW_OFS, STATUS_OFS;
  - the TICK_DIV function of F_CPU.
- One sub-module, servo_channel: holds TARGET and CUR, the slew step and the pin compare.
  - Inputs: clk, rst, frame_start, frame_count, slew, enable_lat, target write strobe and data.
  - Outputs: pin, target, at_target.
  - Instantiated CHANNELS times via generate.
- The top level owns the prescaler, frame counter, ENABLE/SLEW registers and read mux.

Test Plan:
- Reset then idle, default params: all pins low, dout=0; after the first frame_start pins stay low because ENABLE=0.
- Write TARGET0=0, ENABLE=0x01 -> from the next frame, pin0 high for 91*102=9282 clks per 321300-clk frame. TARGET0=255 -> 35292 clks. Other pins stay low.
- Write TARGET1=200 mid-pulse of frame k -> frame k pulse unchanged; frame k+1 width=(91+200)*102 clks; read STATUS bit1=1 with 1-clk latency.
- SLEW=10, CUR2=0, write TARGET2=35, ENABLE bit2 set -> per-frame CUR2 = 10, 20, 30, 35, then holds. STATUS bit2 is 0 until the 35 frame; no overshoot.
- Simultaneous w_en/r_en to TARGET0 (old 5, new 9) -> dout=5 next cycle, then a read returns 9. Read of an unmapped address (BASE+CHANNELS+3) and of upper ENABLE bits -> 0.
- Assert rst while pin0 is high mid-pulse -> pin0 low immediately with no clk edge; all registers 0 after release; counters restart from 0.
